tea_crypt_engine: RTL and testbench

//  Iterative TEA block-cipher engine. Encrypts one 64-bit block with a 128-bit key.

---
 rtl/tea_pkg.sv | 18 +
 rtl/tea_round.sv | 47 ++++
 rtl/tea_crypt_engine.sv | 120 ++++++++++++
 tb/tb_tea_crypt_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared types, constants and the TEA mixing function for the TEA crypt engine.
package tea_pkg;

  typedef logic [31:0] tea_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_e;

  localparam tea_word_t TEA_DELTA = 32'h9E3779B9;

  function automatic tea_word_t tea_f(tea_word_t v, tea_word_t ka, tea_word_t kb, tea_word_t sum);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA cycle (two Feistel rounds). Decrypt path exists only
// when TEA_DECRYPT_EN is defined.
module tea_round import tea_pkg::*; #(
  parameter tea_word_t DELTA = TEA_DELTA
) (
  input  tea_word_t    i_v0,
  input  tea_word_t    i_v1,
  input  tea_word_t    i_sum,
  input  logic [127:0] i_key,
`ifdef TEA_DECRYPT_EN
  input  logic         i_mode,
`endif
  output tea_word_t    o_v0,
  output tea_word_t    o_v1,
  output tea_word_t    o_sum
);

  tea_word_t w_k0, w_k1, w_k2, w_k3;
  tea_word_t w_enc_sum, w_enc_v0, w_enc_v1;

  assign w_k0 = i_key[127:96];
  assign w_k1 = i_key[95:64];
  assign w_k2 = i_key[63:32];
  assign w_k3 = i_key[31:0];

  assign w_enc_sum = i_sum + DELTA;
  assign w_enc_v0  = i_v0 + tea_f(i_v1, w_k0, w_k1, w_enc_sum);
  assign w_enc_v1  = i_v1 + tea_f(w_enc_v0, w_k2, w_k3, w_enc_sum);

`ifdef TEA_DECRYPT_EN
  tea_word_t w_dec_v0, w_dec_v1, w_dec_sum;

  // Decrypt undoes the encrypt steps in reverse, using sum before decrementing.
  assign w_dec_v1  = i_v1 - tea_f(i_v0, w_k2, w_k3, i_sum);
  assign w_dec_v0  = i_v0 - tea_f(w_dec_v1, w_k0, w_k1, i_sum);
  assign w_dec_sum = i_sum - DELTA;

  assign o_v0  = i_mode ? w_dec_v0  : w_enc_v0;
  assign o_v1  = i_mode ? w_dec_v1  : w_enc_v1;
  assign o_sum = i_mode ? w_dec_sum : w_enc_sum;
`else
  assign o_v0  = w_enc_v0;
  assign o_v1  = w_enc_v1;
  assign o_sum = w_enc_sum;
`endif

endmodule

// File: rtl/tea_crypt_engine.sv
// Iterative TEA engine: persistent key, UNROLL cycles per clock, held result with ack.
// Define TEA_DECRYPT_EN to add the i_mode port and the decrypt datapath.
module tea_crypt_engine import tea_pkg::*; #(
  parameter int unsigned NUM_CYCLES = 32,
  parameter int unsigned UNROLL     = 1,
  parameter tea_word_t   DELTA      = TEA_DELTA
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_key_valid,
  input  logic [127:0] i_key,
  input  logic         i_ptxt_valid,
  output logic         o_in_ready,
  input  logic [63:0]  i_ptxt,
`ifdef TEA_DECRYPT_EN
  input  logic         i_mode,
`endif
  output logic [63:0]  o_ctxt,
  output logic         o_ctxt_ready,
  input  logic         i_ctxt_ack,
  output logic         o_busy
);

  tea_state_e   r_state, w_state_d;
  logic [127:0] r_key;
  logic         r_key_loaded;
  tea_word_t    r_v0, r_v1, r_sum;
  logic [31:0]  r_cnt;
  logic [63:0]  r_ctxt;
  logic         w_accept, w_last;

  tea_word_t w_v0  [UNROLL+1];
  tea_word_t w_v1  [UNROLL+1];
  tea_word_t w_sum [UNROLL+1];

`ifdef TEA_DECRYPT_EN
  localparam tea_word_t SumDec = DELTA * tea_word_t'(NUM_CYCLES);
  logic r_mode;
`endif

  assign w_v0[0]  = r_v0;
  assign w_v1[0]  = r_v1;
  assign w_sum[0] = r_sum;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    tea_round #(
      .DELTA (DELTA)
    ) u_round (
      .i_v0  (w_v0[g]),
      .i_v1  (w_v1[g]),
      .i_sum (w_sum[g]),
      .i_key (r_key),
`ifdef TEA_DECRYPT_EN
      .i_mode(r_mode),
`endif
      .o_v0  (w_v0[g+1]),
      .o_v1  (w_v1[g+1]),
      .o_sum (w_sum[g+1])
    );
  end

  always_comb begin
    o_in_ready   = (r_state == IDLE) && (r_key_loaded || i_key_valid);
    o_ctxt_ready = (r_state == DONE);
    o_busy       = (r_state != IDLE);
    o_ctxt       = r_ctxt;
    w_accept     = o_in_ready && i_ptxt_valid;
    w_last       = (r_state == RUN) && ((r_cnt + UNROLL) == NUM_CYCLES);
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_d = RUN;
      RUN:     if (w_last) w_state_d = DONE;
      DONE:    if (i_ctxt_ack) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_key        <= '0;
      r_key_loaded <= 1'b0;
      r_v0         <= '0;
      r_v1         <= '0;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_ctxt       <= '0;
`ifdef TEA_DECRYPT_EN
      r_mode       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && i_key_valid) begin
        r_key        <= i_key;
        r_key_loaded <= 1'b1;
      end
      if (w_accept) begin
        r_v0  <= i_ptxt[63:32];
        r_v1  <= i_ptxt[31:0];
        r_cnt <= '0;
`ifdef TEA_DECRYPT_EN
        r_mode <= i_mode;
        r_sum  <= i_mode ? SumDec : '0;
`else
        r_sum  <= '0;
`endif
      end else if (r_state == RUN) begin
        r_v0  <= w_v0[UNROLL];
        r_v1  <= w_v1[UNROLL];
        r_sum <= w_sum[UNROLL];
        r_cnt <= r_cnt + UNROLL;
        if (w_last) r_ctxt <= {w_v0[UNROLL], w_v1[UNROLL]};
      end
    end
  end

endmodule

// File: tb/tb_tea_crypt_engine.sv
// Bench for tea_crypt_engine: four configurations driven in lock-step from shared inputs.
module tb_tea_crypt_engine;

  localparam int NC [4] = '{32, 32, 32, 4};
  localparam int UN [4] = '{1, 2, 4, 4};
  localparam logic [63:0] ZeroCt = 64'h41EA3A0A94BAA940;

  logic         clk = 1'b0;
  logic         rst_n, key_valid, ptxt_valid, ctxt_ack, mode;
  logic [127:0] key;
  logic [63:0]  ptxt;
  logic         in_rdy [4];
  logic         done   [4];
  logic         busy   [4];
  logic [63:0]  ctxt   [4];

  int          checks = 0;
  int          failures = 0;
  int          lat [4];
  logic [63:0] res [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    tea_crypt_engine #(
      .NUM_CYCLES(NC[g]),
      .UNROLL    (UN[g])
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_key_valid (key_valid),
      .i_key       (key),
      .i_ptxt_valid(ptxt_valid),
      .o_in_ready  (in_rdy[g]),
      .i_ptxt      (ptxt),
`ifdef TEA_DECRYPT_EN
      .i_mode      (mode),
`endif
      .o_ctxt      (ctxt[g]),
      .o_ctxt_ready(done[g]),
      .i_ctxt_ack  (ctxt_ack),
      .o_busy      (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tea_model(logic [127:0] k, logic [63:0] p, int n, bit dec);
    logic [31:0] v0, v1, sum, d;
    d   = 32'h9E3779B9;
    v0  = p[63:32];
    v1  = p[31:0];
    sum = dec ? d * 32'(n) : 32'h0;
    for (int i = 0; i < n; i++) begin
      if (!dec) begin
        sum += d;
        v0 += ((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]);
        v1 += ((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]);
      end else begin
        v1 -= ((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]);
        v0 -= ((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]);
        sum -= d;
      end
    end
    return {v0, v1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] k, input logic kv, input logic [63:0] p,
                           input logic md);
    int n;
    key = k; key_valid = kv; ptxt = p; mode = md; ptxt_valid = 1'b1;
    #1;
    check_eq("accept_ready", 64'(in_rdy[0]), 64'd1);
    step();
    key_valid = 1'b0; ptxt_valid = 1'b0;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    n = 0;
    while (!done[0] && n < 64) begin
      step();
      n++;
      for (int i = 0; i < 4; i++) if (done[i] && lat[i] == 0) lat[i] = n;
    end
    if (!done[0]) check_eq("run_timeout", 64'(done[0]), 64'd1);
    for (int i = 0; i < 4; i++) res[i] = ctxt[i];
  endtask

  task automatic ack();
    ctxt_ack = 1'b1;
    step();
    ctxt_ack = 1'b0;
  endtask

  initial begin
    logic [127:0] k1, k2;
    logic [63:0]  pts [3];
    logic [63:0]  ct;
    bit           stable;

    rst_n = 1'b0; key_valid = 1'b0; ptxt_valid = 1'b0; ctxt_ack = 1'b0; mode = 1'b0;
    key = '0; ptxt = '0;
    repeat (3) step();
    check_eq("rst_ctxt", ctxt[0], 64'h0);
    check_eq("rst_ready", 64'(done[0]), 64'd0);
    check_eq("rst_in_ready", 64'(in_rdy[0]), 64'd0);
    check_eq("rst_busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1;

    // No key ever loaded: block must be ignored.
    ptxt_valid = 1'b1; ptxt = 64'h1234;
    repeat (3) step();
    check_eq("nokey_busy", 64'(busy[0]), 64'd0);
    check_eq("nokey_in_ready", 64'(in_rdy[0]), 64'd0);
    ptxt_valid = 1'b0;

    // All-zero vector, key loaded in the accept cycle.
    run_block('0, 1'b1, 64'h0, 1'b0);
    check_eq("zero_u1", res[0], ZeroCt);
    check_eq("zero_u2", res[1], ZeroCt);
    check_eq("zero_u4", res[2], ZeroCt);
    check_eq("zero_c4", res[3], tea_model('0, 64'h0, 4, 1'b0));
    check_eq("lat_u1", 64'(lat[0]), 64'd32);
    check_eq("lat_u2", 64'(lat[1]), 64'd16);
    check_eq("lat_u4", 64'(lat[2]), 64'd8);
    check_eq("lat_c4", 64'(lat[3]), 64'd1);

    // Backpressure: result held while ack is low.
    stable = 1'b1;
    ptxt_valid = 1'b1; key_valid = 1'b1; key = {4{32'hDEADBEEF}};
    repeat (10) begin
      step();
      stable &= done[0] && (ctxt[0] == ZeroCt) && !in_rdy[0] && busy[0];
    end
    ptxt_valid = 1'b0; key_valid = 1'b0;
    check_eq("done_hold", 64'(stable), 64'd1);
    ack();
    check_eq("ack_ready", 64'(done[0]), 64'd0);
    check_eq("ack_busy", 64'(busy[0]), 64'd0);
    check_eq("ack_ctxt_kept", ctxt[0], ZeroCt);
    check_eq("ack_in_ready", 64'(in_rdy[0]), 64'd1);

    // Stored key reused by back-to-back blocks; i_key carries junk meanwhile.
    k1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    pts = '{64'h0123456789ABCDEF, 64'hFFFFFFFF00000000, 64'h00000001FFFFFFFF};
    key = k1; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      run_block(~k1, 1'b0, pts[b], 1'b0);
      check_eq($sformatf("stored_key_u1_%0d", b), res[0], tea_model(k1, pts[b], 32, 1'b0));
      check_eq($sformatf("stored_key_u4_%0d", b), res[2], tea_model(k1, pts[b], 32, 1'b0));
      check_eq($sformatf("stored_key_c4_%0d", b), res[3], tea_model(k1, pts[b], 4, 1'b0));
      ack();
    end

`ifdef TEA_DECRYPT_EN
    run_block('0, 1'b1, ZeroCt, 1'b1);
    check_eq("dec_zero_u1", res[0], 64'h0);
    check_eq("dec_zero_u4", res[2], 64'h0);
    ack();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    pts[0] = {$urandom, $urandom};
    ct = tea_model(k2, pts[0], 32, 1'b0);
    run_block(k2, 1'b1, pts[0], 1'b0);
    check_eq("rt_enc", res[0], ct);
    ack();
    run_block(k2, 1'b1, ct, 1'b1);
    check_eq("rt_dec_u1", res[0], pts[0]);
    check_eq("rt_dec_u2", res[1], pts[0]);
    ack();
`else
    k2 = '0;
`endif

    // Reset mid-RUN discards the block and forgets the key.
    key = k1 ^ k2; key_valid = 1'b1; ptxt = 64'h55; ptxt_valid = 1'b1;
    step();
    key_valid = 1'b0; ptxt_valid = 1'b0;
    repeat (5) step();
    check_eq("mid_run_busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    step();
    check_eq("mrst_ctxt", ctxt[0], 64'h0);
    check_eq("mrst_ready", 64'(done[0]), 64'd0);
    check_eq("mrst_busy", 64'(busy[0]), 64'd0);
    check_eq("mrst_in_ready", 64'(in_rdy[0]), 64'd0);
    rst_n = 1'b1;
    ptxt_valid = 1'b1;
    repeat (3) step();
    check_eq("post_rst_busy", 64'(busy[0]), 64'd0);
    check_eq("post_rst_in_ready", 64'(in_rdy[0]), 64'd0);
    ptxt_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
